// File: rtl/dvs_pkg.sv
// Shared types and constants for the DVS event deframer.
package dvs_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef struct packed {
        logic [6:0] x;
        logic [6:0] y;
        logic       pol;
    } dvs_event_t;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        GET_X   = 3'd1,
        GET_Y   = 3'd2,
        GET_P   = 3'd3,
        GET_CHK = 3'd4
    } parser_state_e;

    // A packet is good when the checksum matches and every reserved bit is clear.
    function automatic logic packet_ok(input logic [7:0] x,
                                       input logic [7:0] y,
                                       input logic [7:0] p,
                                       input logic [7:0] chk);
        return (chk == (x ^ y ^ p)) && !x[7] && !y[7] && (p[7:1] == 7'd0);
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Show-ahead event buffer; the head entry is visible on pop_data whenever
// empty is low, and reads as zero when empty so the outputs are clean.
module event_fifo
    import dvs_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  dvs_event_t push_data,
    output logic       full,
    input  logic       pop,
    output dvs_event_t pop_data,
    output logic       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    dvs_event_t    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a push while full still lands.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_event_parser.sv
// Deframes 5-byte DVS packets from the UART byte stream and buffers the
// decoded events; errors and drops are pulsed and counted, never stalled.
//
// state   | meaning
// HUNT    | waiting for the 0xA5 sync byte, other bytes ignored
// GET_X   | expecting the X byte
// GET_Y   | expecting the Y byte
// GET_P   | expecting the polarity byte
// GET_CHK | expecting the checksum; validate and push or flag error
module uart_event_parser
    import dvs_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int TIMEOUT_CLKS = 4160
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic [6:0]  ev_x,
    output logic [6:0]  ev_y,
    output logic        ev_pol,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic        pkt_err,
    output logic        ev_drop,
    output logic [15:0] err_cnt,
    output logic [15:0] drop_cnt
);

    localparam int             TW      = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CLKS - 1);

    parser_state_e state;
    parser_state_e next_state;
    logic [7:0]    x_byte;
    logic [7:0]    y_byte;
    logic [7:0]    p_byte;
    logic [TW-1:0] idle_cnt;
    logic          timeout_hit;
    logic          push_ev;
    logic          err_set;
    logic          drop_set;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop_ev;
    dvs_event_t    push_data;
    dvs_event_t    head;

    // A byte on the terminal idle cycle takes priority over the timeout.
    assign timeout_hit = (state != HUNT) && !in_valid && (idle_cnt == TO_LAST);
    assign pop_ev      = !fifo_empty && ev_ready;
    assign drop_set    = push_ev && fifo_full && !pop_ev;
    assign push_data   = '{x: x_byte[6:0], y: y_byte[6:0], pol: p_byte[0]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= HUNT;
        else        state <= next_state;
    end

    // Next-state decode, packet validation and error detection.
    always_comb begin
        next_state = state;
        push_ev    = 1'b0;
        err_set    = 1'b0;
        case (state)
            HUNT: begin
                if (in_valid && (in_data == SYNC_BYTE)) next_state = GET_X;
            end
            GET_X: begin
                if (in_valid) next_state = GET_Y;
                else if (timeout_hit) begin
                    next_state = HUNT;
                    err_set    = 1'b1;
                end
            end
            GET_Y: begin
                if (in_valid) next_state = GET_P;
                else if (timeout_hit) begin
                    next_state = HUNT;
                    err_set    = 1'b1;
                end
            end
            GET_P: begin
                if (in_valid) next_state = GET_CHK;
                else if (timeout_hit) begin
                    next_state = HUNT;
                    err_set    = 1'b1;
                end
            end
            GET_CHK: begin
                if (in_valid) begin
                    next_state = HUNT;
                    if (packet_ok(x_byte, y_byte, p_byte, in_data)) push_ev = 1'b1;
                    else                                            err_set = 1'b1;
                end else if (timeout_hit) begin
                    next_state = HUNT;
                    err_set    = 1'b1;
                end
            end
            default: next_state = HUNT;
        endcase
    end

    // Payload byte capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_byte <= '0;
            y_byte <= '0;
            p_byte <= '0;
        end else if (in_valid) begin
            if (state == GET_X) x_byte <= in_data;
            if (state == GET_Y) y_byte <= in_data;
            if (state == GET_P) p_byte <= in_data;
        end
    end

    // Inter-byte idle counter; cleared by any byte and held at zero in HUNT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         idle_cnt <= '0;
        else if (state == HUNT || in_valid) idle_cnt <= '0;
        else if (idle_cnt != TO_LAST)       idle_cnt <= idle_cnt + 1'b1;
    end

    // Registered status pulses and their saturating counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_err  <= 1'b0;
            ev_drop  <= 1'b0;
            err_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            pkt_err <= err_set;
            ev_drop <= drop_set;
            if (err_set  && (err_cnt  != 16'hFFFF)) err_cnt  <= err_cnt  + 16'd1;
            if (drop_set && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_ev),
        .push_data (push_data),
        .full      (fifo_full),
        .pop       (pop_ev),
        .pop_data  (head),
        .empty     (fifo_empty)
    );

    assign ev_valid = !fifo_empty;
    assign ev_x     = head.x;
    assign ev_y     = head.y;
    assign ev_pol   = head.pol;

endmodule

// File: tb/tb_uart_event_parser.sv
// Directed bench for uart_event_parser.
module tb_uart_event_parser;

    localparam int T = 32;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic [6:0]  ev_x;
    logic [6:0]  ev_y;
    logic        ev_pol;
    logic        ev_valid;
    logic        ev_ready;
    logic        pkt_err;
    logic        ev_drop;
    logic [15:0] err_cnt;
    logic [15:0] drop_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    uart_event_parser #(
        .FIFO_DEPTH   (4),
        .TIMEOUT_CLKS (T)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .ev_x     (ev_x),
        .ev_y     (ev_y),
        .ev_pol   (ev_pol),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .pkt_err  (pkt_err),
        .ev_drop  (ev_drop),
        .err_cnt  (err_cnt),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte is captured on the next rising edge; returns 1 time unit after it.
    task automatic send(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] x, input logic [7:0] y,
                            input logic [7:0] p, input logic [7:0] c);
        send(8'hA5);
        send(x);
        send(y);
        send(p);
        send(c);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop_one();
        ev_ready = 1'b1;
        @(posedge clk);
        #1;
        ev_ready = 1'b0;
    endtask

    task automatic check_ev(input string tag, input logic [6:0] x,
                            input logic [6:0] y, input logic pol);
        check({tag, "_valid"}, {31'd0, ev_valid}, 32'd1);
        check({tag, "_x"},     {25'd0, ev_x},     {25'd0, x});
        check({tag, "_y"},     {25'd0, ev_y},     {25'd0, y});
        check({tag, "_pol"},   {31'd0, ev_pol},   {31'd0, pol});
    endtask

    initial begin
        logic [7:0] ox, oy, op;

        rst_n    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        ev_ready = 1'b0;
        idle(3);

        check("rst_valid",    {31'd0, ev_valid}, 32'd0);
        check("rst_x",        {25'd0, ev_x},     32'd0);
        check("rst_y",        {25'd0, ev_y},     32'd0);
        check("rst_pol",      {31'd0, ev_pol},   32'd0);
        check("rst_pkt_err",  {31'd0, pkt_err},  32'd0);
        check("rst_ev_drop",  {31'd0, ev_drop},  32'd0);
        check("rst_err_cnt",  {16'd0, err_cnt},  32'd0);
        check("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Clean packet, latency of one cycle after the CHK strobe.
        send(8'hA5); send(8'h12); send(8'h34); send(8'h01);
        check("clean_pre_valid", {31'd0, ev_valid}, 32'd0);
        send(8'h27);
        check_ev("clean", 7'h12, 7'h34, 1'b1);
        check("clean_pkt_err", {31'd0, pkt_err}, 32'd0);
        check("clean_err_cnt", {16'd0, err_cnt}, 32'd0);
        pop_one();
        check("clean_popped", {31'd0, ev_valid}, 32'd0);

        // Bad checksum, then a good packet with polarity 0.
        send_pkt(8'h12, 8'h34, 8'h01, 8'h26);
        check("badchk_pkt_err", {31'd0, pkt_err},  32'd1);
        check("badchk_valid",   {31'd0, ev_valid}, 32'd0);
        check("badchk_err_cnt", {16'd0, err_cnt},  32'd1);
        idle(1);
        check("badchk_pulse_end", {31'd0, pkt_err}, 32'd0);
        send_pkt(8'h05, 8'h06, 8'h00, 8'h03);
        check_ev("pol0", 7'h05, 7'h06, 1'b0);
        pop_one();

        // Leading junk is silent; sync found afterwards.
        send(8'h00); send(8'hFF); send(8'h5A);
        check("junk_pkt_err", {31'd0, pkt_err}, 32'd0);
        check("junk_err_cnt", {16'd0, err_cnt}, 32'd1);
        send_pkt(8'h7F, 8'h00, 8'h00, 8'h7F);
        check_ev("junk_pkt", 7'h7F, 7'h00, 1'b0);
        pop_one();
        send_pkt(8'h80, 8'h00, 8'h00, 8'h80);
        check("xbit7_pkt_err", {31'd0, pkt_err},  32'd1);
        check("xbit7_valid",   {31'd0, ev_valid}, 32'd0);
        check("xbit7_err_cnt", {16'd0, err_cnt},  32'd2);

        // Timeout after T idle clocks inside a packet.
        idle(2);
        send(8'hA5); send(8'h12);
        idle(T - 1);
        check("to_not_yet", {31'd0, pkt_err}, 32'd0);
        idle(1);
        check("to_pkt_err", {31'd0, pkt_err}, 32'd1);
        check("to_err_cnt", {16'd0, err_cnt}, 32'd3);
        send(8'h34); send(8'h01); send(8'h27);
        check("to_tail_valid",   {31'd0, ev_valid}, 32'd0);
        check("to_tail_pkt_err", {31'd0, pkt_err},  32'd0);
        send_pkt(8'h12, 8'h34, 8'h01, 8'h27);
        check_ev("to_recover", 7'h12, 7'h34, 1'b1);
        pop_one();

        // Byte landing exactly on the terminal idle cycle beats the timeout.
        send(8'hA5); send(8'h12);
        idle(T - 1);
        send(8'h34);
        check("to_edge_pkt_err", {31'd0, pkt_err}, 32'd0);
        send(8'h01); send(8'h27);
        check_ev("to_edge", 7'h12, 7'h34, 1'b1);
        check("to_edge_err_cnt", {16'd0, err_cnt}, 32'd3);
        pop_one();

        // Overflow: six good packets into a depth-4 buffer.
        for (int i = 0; i < 6; i++) begin
            ox = 8'h20 + 8'(i);
            oy = 8'h40 + 8'(i);
            op = {7'd0, i[0]};
            send_pkt(ox, oy, op, ox ^ oy ^ op);
            check($sformatf("ovf_drop_%0d", i), {31'd0, ev_drop}, (i >= 4) ? 32'd1 : 32'd0);
        end
        check("ovf_drop_cnt", {16'd0, drop_cnt}, 32'd2);
        check_ev("ovf_head0", 7'h20, 7'h40, 1'b0);

        // Push and pop together while full: no drop, order kept.
        send(8'hA5); send(8'h26); send(8'h46); send(8'h00);
        ev_ready = 1'b1;
        send(8'h26 ^ 8'h46);
        check("pp_drop",     {31'd0, ev_drop},  32'd0);
        check("pp_drop_cnt", {16'd0, drop_cnt}, 32'd2);
        check_ev("drain1", 7'h21, 7'h41, 1'b1);
        idle(1);
        check_ev("drain2", 7'h22, 7'h42, 1'b0);
        idle(1);
        check_ev("drain3", 7'h23, 7'h43, 1'b1);
        idle(1);
        check_ev("drain4", 7'h26, 7'h46, 1'b0);
        idle(1);
        check("drain_empty", {31'd0, ev_valid}, 32'd0);
        ev_ready = 1'b0;

        // Reset mid-packet flushes buffered events and the partial packet.
        send_pkt(8'h01, 8'h02, 8'h01, 8'h02);
        check("prerst_valid", {31'd0, ev_valid}, 32'd1);
        send(8'hA5); send(8'h12); send(8'h34);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid",    {31'd0, ev_valid}, 32'd0);
        check("midrst_x",        {25'd0, ev_x},     32'd0);
        check("midrst_err_cnt",  {16'd0, err_cnt},  32'd0);
        check("midrst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        send(8'h01); send(8'h27);
        check("postrst_valid",   {31'd0, ev_valid}, 32'd0);
        check("postrst_pkt_err", {31'd0, pkt_err},  32'd0);
        send_pkt(8'h12, 8'h34, 8'h01, 8'h27);
        check_ev("postrst", 7'h12, 7'h34, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_event_parser.md
# uart_event_parser

Byte-to-event deframer directly downstream of the UART receiver. Consumes the 8N1 byte stream (one-cycle `valid` strobes, no backpressure) and assembles 5-byte DVS event packets. Validates each packet, then delivers decoded (x, y, polarity) events through a small buffered valid/ready port to the classifier front end. Errors and overflows are counted rather than stalled, because the UART cannot be throttled.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: output event buffer depth; must be a power of 2 and ≥2.
- `TIMEOUT_CLKS`, default 4160: maximum idle clocks between bytes inside a packet (four byte-times at 12 MHz / 115200).

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_data` in 8: received byte.
- `in_valid` in 1: one-cycle strobe, `in_data` valid; no ready.
- `ev_x` out 7: head event x coordinate.
- `ev_y` out 7: head event y coordinate.
- `ev_pol` out 1: head event polarity (1 = ON).
- `ev_valid` out 1: head event present.
- `ev_ready` in 1: consumer accepts the head event.
- `pkt_err` out 1: one-cycle pulse on a rejected packet or a timeout.
- `ev_drop` out 1: one-cycle pulse when a good event is lost because the FIFO is full.
- `err_cnt` out 16: saturating count of `pkt_err` pulses.
- `drop_cnt` out 16: saturating count of `ev_drop` pulses.

## Operation
Packet format, in arrival order:
- SYNC = 0xA5.
- X: bit7 must be 0.
- Y: bit7 must be 0.
- P: bit0 = polarity; bits7:1 must be 0.
- CHK = X ^ Y ^ P.

FSM states: HUNT, GET_X, GET_Y, GET_P, GET_CHK.
- HUNT: a byte equal to 0xA5 moves to GET_X. Any other byte is discarded silently (no `pkt_err`).
- GET_X → GET_Y → GET_P → GET_CHK: each byte is latched on `in_valid`.
- No resync inside a packet: 0xA5 arriving in GET_X..GET_CHK is ordinary data.
- GET_CHK on `in_valid`:
  - Pass requires: CHK matches, X[7]=0, Y[7]=0, P[7:1]=0. On pass, push {X[6:0], Y[6:0], P[0]}.
  - On fail, pulse `pkt_err`.
  - Always return to HUNT.
- Timeout: the idle counter resets on every accepted byte. It counts only outside HUNT. On reaching TIMEOUT_CLKS−1 with no byte: go to HUNT, pulse `pkt_err`. A byte arriving on that same cycle wins and no timeout occurs.

FIFO:
- Show-ahead: `ev_*` always reflect the head entry when `ev_valid`=1.
- Pop on `ev_valid && ev_ready`.
- Push while full and pop in the same cycle: both occur, no drop.
- Push while full with no pop: event discarded, `ev_drop` pulses.
- Push while empty: allowed as normal.

Counters:
- Increment on their pulse.
- Hold at 0xFFFF (saturate).

## Timing
- Reset (async assert, sync release) values:
  - FSM = HUNT; FIFO empty.
  - `ev_valid`=0; `ev_x`=`ev_y`=0; `ev_pol`=0.
  - `pkt_err`=`ev_drop`=0; `err_cnt`=`drop_cnt`=0.
- Reset mid-packet discards the partial packet and all buffered events.
- Latency: CHK byte strobe on cycle N → `ev_valid`=1 on cycle N+1 when the FIFO was empty.
- `pkt_err` and `ev_drop` are registered and asserted on cycle N+1.
- Back-to-back `in_valid` on consecutive cycles must be handled, although the UART never produces this.
- `ev_ready` may be held high continuously: one event per cycle drains.
- Timeout counter width: `$clog2(TIMEOUT_CLKS)`.

## Structure
- Shared package `dvs_pkg`:
  - `SYNC_BYTE` = 8'hA5.
  - `dvs_event_t` packed struct {x[6:0], y[6:0], pol}.
  - `parser_state_e` enum.
- Sub-module `event_fifo`:
  - Parameterised synchronous show-ahead FIFO of `dvs_event_t`.
  - Ports: push/full, pop/empty.
  - Same clock and reset as the parent.
- Parent module holds the FSM, timeout logic and counters.

## Test plan
- Clean packet: A5 12 34 01 27 → one event x=0x12, y=0x34, pol=1, `ev_valid` one cycle after the 0x27 strobe; `err_cnt`=0.
- Bad checksum: A5 12 34 01 26 → no event, `pkt_err` pulse, `err_cnt`=1. Then A5 05 06 00 03 → event x=5, y=6, pol=0.
- Garbage then packet: 00 FF 5A A5 7F 00 00 7F → no `pkt_err` for the leading junk; event x=0x7F, y=0, pol=0. Also A5 80 00 00 80 → `pkt_err` (X bit7 set).
- Timeout: A5 12, then TIMEOUT_CLKS idle clocks → `pkt_err` and FSM back to HUNT. Then 34 01 27 → no event; A5 12 34 01 27 → event.
- Overflow: `ev_ready`=0, send 6 good packets → first 4 buffered, 2 `ev_drop` pulses, `drop_cnt`=2. Then raise `ev_ready` → 4 events pop in order. Also push and pop on the same cycle while full → no drop.
- Reset mid-packet: assert `rst_n`=0 after A5 12 34 → outputs at reset values. Then 01 27 → no event; a full packet → event.
